seg_scanner: RTL and testbench
==============================

Name: seg_scanner

Overview:
- Consumer end of the timer's 7-segment digit interface.
- Takes the four per-digit segment patterns (seconds low/high, minutes low/high) and time-multiplexes them onto one shared segment bus with active-low anode selects for the board's 4-digit common-anode display.
- Adds inter-digit blanking against ghosting, frame-coherent snapshotting against tearing, a decimal-point separator, and a blink mode for the game-over display.

Parameters:
- DIV, 50000, clock cycles per digit slot; legal range DIV >= 2.
- BLANK, 500, blanking cycles at the start of each slot; legal range 0 < BLANK < DIV.
- BLINK_FRAMES, 64, completed frames per blink half-period; legal range >= 1.

Ports:
- clk  in  1  system clock, single clock domain
- rst  in  1  synchronous, active-high reset
- led_sec_l  in  7  seconds-units pattern, active-low; bit6=a ... bit0=g
- led_sec_h  in  7  seconds-tens pattern, same encoding
- led_min_l  in  7  minutes-units pattern, same encoding
- led_min_h  in  7  minutes-tens pattern, same encoding
- blink  in  1  level; high requests a flashing display (driven from game_over)
- seg  out  7  shared segment bus, active-low, same bit order as inputs
- dp  out  1  decimal point, active-low
- an  out  4  digit anode selects, active-low; an[0]=sec_l, an[1]=sec_h, an[2]=min_l, an[3]=min_h

Behaviour:
- One clock. Reset is synchronous, active-high, sampled on posedge clk only.
- Reset state: state=BLANK, digit index idx=0, slot counter cnt=0, an=4'b1111, seg=7'b1111111, dp=1, all four snapshots=7'b1111111, blink phase=ON, frame counter=0.
- Reset asserted mid-operation returns to the reset state on that edge, whatever the current state.
- Frame = 4 slots in the order idx 0,1,2,3. Each slot = DIV cycles; cnt runs 0..DIV-1, width $clog2(DIV).
- State machine:
  - BLANK -> SHOW when cnt==BLANK-1.
  - SHOW -> BLANK when cnt==DIV-1; at that edge cnt clears and idx increments mod 4.
- Outputs are registers updated on the same edge as the state, so an is low for exactly DIV-BLANK cycles per slot and high for exactly BLANK cycles per slot.
- BLANK outputs: an=4'b1111, seg=7'b1111111, dp=1.
- SHOW outputs:
  - an has only bit idx low.
  - seg = snapshot[idx].
  - dp=0 only when idx==2 (minutes:seconds separator); otherwise dp=1.
- Snapshot: all four inputs are captured together on the first cycle of each frame (state BLANK, idx==0, cnt==0), including the first cycle after reset. Input changes inside a frame are not visible until the next frame.
- Patterns pass through unmodified; illegal or blank patterns are displayed as given.
- Blink:
  - blink=0: phase forced ON, frame counter held at 0.
  - blink=1: the frame counter increments at each frame end (idx 3 -> 0). When it reaches BLINK_FRAMES it clears and the phase toggles.
  - Phase changes only at frame boundaries.
  - Phase OFF: an stays 4'b1111 and dp stays 1 during SHOW. seg and the timing are unchanged.
  - blink falling mid-frame: phase returns to ON at the next frame boundary.

Optional Feature:
- Macro: SEG_SCANNER_LEADING_ZERO_BLANK_EN.
- Defined: during slot 3 SHOW, if snapshot min_h == 7'b0000001 (digit 0), an[3] stays 1.
- Undefined: min_h is always shown, including a leading zero.

Test Plan:
- Reset (DIV=8, BLANK=2): hold rst 3 cycles -> an=1111, seg=1111111, dp=1 while held. After release: an=1111 for cycles 0-1, an=1110 for cycles 2-7, an=1111 for cycles 8-9, an=1101 for cycles 10-15.
- Snapshot: sec_l=7'b1001111 ("1") at frame start, changed to 7'b0010010 ("2") during slot 1 -> slot 0 of the current frame shows 1001111; slot 0 of the next frame shows 0010010.
- dp: any input pattern -> dp=0 only during slot-2 SHOW cycles (cycles 18-23 of a frame with DIV=8); dp=1 at all other times.
- Blink (BLINK_FRAMES=2): raise blink at a frame start -> frames 0-1 lit, frames 2-3 an=1111 throughout, frames 4-5 lit. Drop blink during a dark frame -> the next frame is lit.
- Reset mid-slot-2 SHOW: rst high 1 cycle -> next cycle an=1111, idx=0. The sequence restarts exactly as in the first scenario.
- Macro defined, min_h=7'b0000001 -> an[3] never low; min_h=7'b1001111 -> an[3] low for DIV-BLANK cycles per frame. Macro undefined: zero is shown.

Source files
------------

// File: rtl/seg_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seg_scanner                                                  |
// | Description : Multiplexes four snapshotted 7-segment patterns onto a       |
// |               4-digit common-anode display with blanking, separator dot    |
// |               and blink. Optional: SEG_SCANNER_LEADING_ZERO_BLANK_EN.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seg_scanner #(
    parameter int DIV          = 50000,
    parameter int BLANK        = 500,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] led_sec_l,
    input  logic [6:0] led_sec_h,
    input  logic [6:0] led_min_l,
    input  logic [6:0] led_min_h,
    input  logic       blink,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int c_cnt_w = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int c_frm_w = $clog2(BLINK_FRAMES + 1);

    localparam logic [c_cnt_w-1:0] c_blank_end = c_cnt_w'(BLANK - 1);
    localparam logic [c_cnt_w-1:0] c_slot_end  = c_cnt_w'(DIV - 1);
    localparam logic [c_frm_w-1:0] c_frm_last  = c_frm_w'(BLINK_FRAMES - 1);
    localparam logic [6:0]         c_seg_off   = 7'b1111111;
    localparam logic [3:0]         c_an_off    = 4'b1111;
    localparam logic [1:0]         c_idx_dp    = 2'd2;
    localparam logic [1:0]         c_idx_last  = 2'd3;

    generate
        if (DIV < 2) begin : g_chk_div
            $error("seg_scanner: DIV must be >= 2");
        end
        if ((BLANK < 1) || (BLANK >= DIV)) begin : g_chk_blank
            $error("seg_scanner: BLANK must satisfy 0 < BLANK < DIV");
        end
        if (BLINK_FRAMES < 1) begin : g_chk_blink
            $error("seg_scanner: BLINK_FRAMES must be >= 1");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [1:0]           r_idx;
    logic [6:0]           r_snap [4];
    logic                 r_phase_on;
    logic [c_frm_w-1:0]   r_frm_cnt;

    logic                 w_frame_start;
    logic                 w_to_show;
    logic                 w_to_blank;
    logic [6:0]           w_snap_nxt [4];
    logic [6:0]           w_seg_sel;
    logic [3:0]           w_an_sel;
    logic                 w_lz_hide;

    assign w_frame_start = (r_state == ST_BLANK) && (r_idx == 2'd0) && (r_cnt == '0);
    assign w_to_show     = (r_state == ST_BLANK) && (r_cnt == c_blank_end);
    assign w_to_blank    = (r_state == ST_SHOW)  && (r_cnt == c_slot_end);

    // The capture cycle may coincide with the first SHOW edge when BLANK==1,
    // so the displayed pattern is taken from the post-capture view.
    always_comb begin
        w_snap_nxt[0] = r_snap[0];
        w_snap_nxt[1] = r_snap[1];
        w_snap_nxt[2] = r_snap[2];
        w_snap_nxt[3] = r_snap[3];
        if (w_frame_start) begin
            w_snap_nxt[0] = led_sec_l;
            w_snap_nxt[1] = led_sec_h;
            w_snap_nxt[2] = led_min_l;
            w_snap_nxt[3] = led_min_h;
        end
    end

    assign w_seg_sel = w_snap_nxt[r_idx];
    assign w_an_sel  = ~(4'b0001 << r_idx);

`ifdef SEG_SCANNER_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] c_digit_zero = 7'b0000001;
    assign w_lz_hide = (r_idx == c_idx_last) && (w_snap_nxt[3] == c_digit_zero);
`else
    assign w_lz_hide = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_BLANK;
            r_cnt      <= '0;
            r_idx      <= 2'd0;
            r_phase_on <= 1'b1;
            r_frm_cnt  <= '0;
            an         <= c_an_off;
            seg        <= c_seg_off;
            dp         <= 1'b1;
            for (int i = 0; i < 4; i++) begin
                r_snap[i] <= c_seg_off;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                r_snap[i] <= w_snap_nxt[i];
            end

            case (r_state)
                ST_BLANK: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_to_show) begin
                        r_state <= ST_SHOW;
                        seg     <= w_seg_sel;
                        an      <= (r_phase_on && !w_lz_hide) ? w_an_sel : c_an_off;
                        dp      <= !(r_phase_on && (r_idx == c_idx_dp));
                    end
                end

                ST_SHOW: begin
                    if (w_to_blank) begin
                        r_state <= ST_BLANK;
                        r_cnt   <= '0;
                        r_idx   <= r_idx + 2'd1;
                        an      <= c_an_off;
                        seg     <= c_seg_off;
                        dp      <= 1'b1;
                        // Blink phase only ever moves at the frame boundary.
                        if (r_idx == c_idx_last) begin
                            if (!blink) begin
                                r_phase_on <= 1'b1;
                                r_frm_cnt  <= '0;
                            end else if (r_frm_cnt == c_frm_last) begin
                                r_phase_on <= !r_phase_on;
                                r_frm_cnt  <= '0;
                            end else begin
                                r_frm_cnt  <= r_frm_cnt + 1'b1;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_BLANK;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_seg_scanner                                               |
// | Description : Directed self-checking bench for seg_scanner (DIV=8,         |
// |               BLANK=2, BLINK_FRAMES=2).                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_seg_scanner;

    localparam int         c_div    = 8;
    localparam int         c_blank  = 2;
    localparam int         c_frame  = 4 * c_div;
    localparam logic [6:0] c_one    = 7'b1001111;
    localparam logic [6:0] c_two    = 7'b0010010;
    localparam logic [6:0] c_three  = 7'b0000110;
    localparam logic [6:0] c_four   = 7'b1001100;
    localparam logic [6:0] c_zero   = 7'b0000001;
`ifdef SEG_SCANNER_LEADING_ZERO_BLANK_EN
    localparam bit         c_lz_en  = 1'b1;
`else
    localparam bit         c_lz_en  = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] led_sec_l, led_sec_h, led_min_l, led_min_h;
    logic       blink;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    int total = 0;
    int bad   = 0;

    seg_scanner #(
        .DIV          (c_div),
        .BLANK        (c_blank),
        .BLINK_FRAMES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .led_sec_l (led_sec_l),
        .led_sec_h (led_sec_h),
        .led_min_l (led_min_l),
        .led_min_h (led_min_h),
        .blink     (blink),
        .seg       (seg),
        .dp        (dp),
        .an        (an)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Walks one full frame from its cycle 0, comparing every cycle against the
    // expected slot timing; optional mid-frame (cycle 12) input disturbances.
    task automatic check_frame(input string tag,
                               input logic [6:0] s0, input logic [6:0] s1,
                               input logic [6:0] s2, input logic [6:0] s3,
                               input bit lit, input bit chg_sec,
                               input logic [6:0] new_sec, input bit drop_blink);
        logic [6:0] snap [4];
        int         slot;
        int         pos;
        bit         show;
        bit         hide;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        snap[0] = s0;
        snap[1] = s1;
        snap[2] = s2;
        snap[3] = s3;
        for (int c = 0; c < c_frame; c++) begin
            slot  = c / c_div;
            pos   = c % c_div;
            show  = (pos >= c_blank);
            hide  = c_lz_en && (slot == 3) && (snap[3] == c_zero);
            e_an  = (show && lit && !hide) ? ~(4'b0001 << slot) : 4'b1111;
            e_seg = show ? snap[slot] : 7'b1111111;
            e_dp  = (show && lit && slot == 2) ? 1'b0 : 1'b1;
            check($sformatf("%s c%0d an", tag, c),  {28'd0, an},  {28'd0, e_an});
            check($sformatf("%s c%0d seg", tag, c), {25'd0, seg}, {25'd0, e_seg});
            check($sformatf("%s c%0d dp", tag, c),  {31'd0, dp},  {31'd0, e_dp});
            if (c == 12) begin
                if (chg_sec)    led_sec_l = new_sec;
                if (drop_blink) blink     = 1'b0;
            end
            tick();
        end
    endtask

    initial begin
        rst       = 1'b1;
        blink     = 1'b0;
        led_sec_l = c_one;
        led_sec_h = c_two;
        led_min_l = c_three;
        led_min_h = c_four;

        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rst%0d an", i),  {28'd0, an},  32'hF);
            check($sformatf("rst%0d seg", i), {25'd0, seg}, 32'h7F);
            check($sformatf("rst%0d dp", i),  {31'd0, dp},  32'h1);
        end
        rst = 1'b0;

        // Snapshot holds sec_l through a mid-frame change.
        check_frame("f0", c_one, c_two, c_three, c_four, 1'b1, 1'b1, c_two, 1'b0);
        check_frame("f1", c_two, c_two, c_three, c_four, 1'b1, 1'b0, c_two, 1'b0);

        led_sec_l = c_one;
        blink     = 1'b1;
        check_frame("b0", c_one, c_two, c_three, c_four, 1'b1, 1'b0, c_one, 1'b0);
        check_frame("b1", c_one, c_two, c_three, c_four, 1'b1, 1'b0, c_one, 1'b0);
        check_frame("b2", c_one, c_two, c_three, c_four, 1'b0, 1'b0, c_one, 1'b0);
        check_frame("b3", c_one, c_two, c_three, c_four, 1'b0, 1'b0, c_one, 1'b0);
        check_frame("b4", c_one, c_two, c_three, c_four, 1'b1, 1'b0, c_one, 1'b0);
        check_frame("b5", c_one, c_two, c_three, c_four, 1'b1, 1'b0, c_one, 1'b0);
        check_frame("b6", c_one, c_two, c_three, c_four, 1'b0, 1'b0, c_one, 1'b1);
        check_frame("b7", c_one, c_two, c_three, c_four, 1'b1, 1'b0, c_one, 1'b0);

        led_min_h = c_zero;
        check_frame("lz0", c_one, c_two, c_three, c_zero, 1'b1, 1'b0, c_one, 1'b0);
        led_min_h = c_one;
        check_frame("lz1", c_one, c_two, c_three, c_one, 1'b1, 1'b0, c_one, 1'b0);

        led_min_h = c_four;
        for (int i = 0; i < 20; i++) tick();
        check("mid s2 an", {28'd0, an}, 32'hB);
        check("mid s2 dp", {31'd0, dp}, 32'h0);
        rst = 1'b1;
        tick();
        check("mid rst an",  {28'd0, an},  32'hF);
        check("mid rst seg", {25'd0, seg}, 32'h7F);
        check("mid rst dp",  {31'd0, dp},  32'h1);
        rst       = 1'b0;
        led_sec_l = c_three;
        check_frame("r0", c_three, c_two, c_three, c_four, 1'b1, 1'b0, c_one, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
